mux_arb_nx1: RTL and testbench

Parametrised N-input, one-output arbitrated multiplexer with a registered output stage and valid/ready handshaking on every channel. It generalises the combinational Nx2x1/Nx4x1/Nx8x1 mux family to any channel count and any data width. It also adds per-cycle arbitration, back-pressure and one output pipeline register. It sits wherever several producers share one consumer, for example writeback and forwarding sources feeding a single bus.

---
 rtl/mux_arb_nx1_if.sv | 25 ++
 rtl/mux_arb_nx1.sv | 103 ++++++++++
 tb/tb_mux_arb_nx1.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/mux_arb_nx1_if.sv
// Handshake bundle for mux_arb_nx1: N producer channels in, one registered beat out.
// The slave modport is the arbiter's view and the master modport is the environment's view.
interface mux_arb_nx1_if #(
   parameter int DATA_WIDTH   = 64,
   parameter int NUM_INPUTS   = 8,
   parameter int SELECT_WIDTH = $clog2(NUM_INPUTS)
);
   logic [NUM_INPUTS-1:0][DATA_WIDTH-1:0] data_i;
   logic [NUM_INPUTS-1:0]                 valid_i;
   logic [NUM_INPUTS-1:0]                 ready_o;
   logic [DATA_WIDTH-1:0]                 data_o;
   logic                                  valid_o;
   logic                                  ready_i;
   logic [SELECT_WIDTH-1:0]               grant_o;

   modport slave (
      input  data_i, valid_i, ready_i,
      output ready_o, data_o, valid_o, grant_o
   );

   modport master (
      output data_i, valid_i, ready_i,
      input  ready_o, data_o, valid_o, grant_o
   );
endinterface

// File: rtl/mux_arb_nx1.sv
// N-to-1 arbitrated mux with a registered output stage and valid/ready on every channel.
// Round-robin by default; define MUX_ARB_FIXED_PRIO_EN for lowest-index-wins priority.
module mux_arb_nx1 #(
   parameter int DATA_WIDTH   = 64,
   parameter int NUM_INPUTS   = 8,
   parameter int SELECT_WIDTH = $clog2(NUM_INPUTS)
) (
   input  logic          clk_i,
   input  logic          reset_i,
   mux_arb_nx1_if.slave  bus
);
   localparam logic [SELECT_WIDTH:0] NUM_W = (SELECT_WIDTH+1)'(NUM_INPUTS);

   logic [DATA_WIDTH-1:0]   data_q, data_d;
   logic [SELECT_WIDTH-1:0] grant_q, grant_d;
   logic                    valid_q, valid_d;
   logic [SELECT_WIDTH-1:0] ptr_w;
   logic [SELECT_WIDTH:0]   cand;
   logic [SELECT_WIDTH-1:0] win_idx;
   logic                    win_found;
   logic                    load_en;
   logic                    xfer;

`ifdef MUX_ARB_FIXED_PRIO_EN
   assign ptr_w = '0;
`else
   logic [SELECT_WIDTH-1:0] ptr_q, ptr_d;
   logic [SELECT_WIDTH:0]   ptr_inc;
   assign ptr_w = ptr_q;
`endif

   // Scan upward from the pointer with wrap; candidates are always < NUM_INPUTS.
   always_comb begin
      win_found = 1'b0;
      win_idx   = '0;
      cand      = '0;
      for (int off = 0; off < NUM_INPUTS; off++) begin
         cand = {1'b0, ptr_w} + (SELECT_WIDTH+1)'(off);
         if (cand >= NUM_W) begin
            cand = cand - NUM_W;
         end
         if (!win_found && bus.valid_i[cand[SELECT_WIDTH-1:0]]) begin
            win_found = 1'b1;
            win_idx   = cand[SELECT_WIDTH-1:0];
         end
      end
   end

   assign load_en = !valid_q || bus.ready_i;
   assign xfer    = load_en && win_found && !reset_i;

   for (genvar gi = 0; gi < NUM_INPUTS; gi++) begin : g_ready
      assign bus.ready_o[gi] = xfer && (win_idx == SELECT_WIDTH'(gi));
   end

   always_comb begin
      data_d  = data_q;
      grant_d = grant_q;
      valid_d = valid_q;
      if (xfer) begin
         data_d  = bus.data_i[win_idx];
         grant_d = win_idx;
         valid_d = 1'b1;
      end else if (bus.ready_i) begin
         valid_d = 1'b0;
      end
   end

`ifndef MUX_ARB_FIXED_PRIO_EN
   always_comb begin
      ptr_d   = ptr_q;
      ptr_inc = {1'b0, win_idx} + (SELECT_WIDTH+1)'(1);
      if (xfer) begin
         ptr_d = (ptr_inc == NUM_W) ? '0 : ptr_inc[SELECT_WIDTH-1:0];
      end
   end

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         ptr_q <= '0;
      end else begin
         ptr_q <= ptr_d;
      end
   end
`endif

   // A held beat is discarded the moment reset rises.
   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         data_q  <= '0;
         grant_q <= '0;
         valid_q <= 1'b0;
      end else begin
         data_q  <= data_d;
         grant_q <= grant_d;
         valid_q <= valid_d;
      end
   end

   assign bus.data_o  = data_q;
   assign bus.grant_o = grant_q;
   assign bus.valid_o = valid_q;
endmodule

// File: tb/tb_mux_arb_nx1.sv
// Directed bench for mux_arb_nx1: an 8-channel and a 5-channel instance on one clock.
module tb_mux_arb_nx1;
   logic clk;
   logic rst8;
   logic rst5;
   int   pass_cnt;
   int   total_cnt;

   mux_arb_nx1_if #(.DATA_WIDTH(64), .NUM_INPUTS(8)) bus8 ();
   mux_arb_nx1_if #(.DATA_WIDTH(64), .NUM_INPUTS(5)) bus5 ();

   mux_arb_nx1 #(.DATA_WIDTH(64), .NUM_INPUTS(8)) dut8 (
      .clk_i   (clk),
      .reset_i (rst8),
      .bus     (bus8)
   );

   mux_arb_nx1 #(.DATA_WIDTH(64), .NUM_INPUTS(5)) dut5 (
      .clk_i   (clk),
      .reset_i (rst5),
      .bus     (bus5)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic test_reset();
      @(negedge clk);
      bus8.valid_i = 8'hFF;
      #1;
      total_cnt++;
      if (bus8.ready_o !== 8'h00) $display("FAIL reset_ready: got %h want 00", bus8.ready_o);
      else pass_cnt++;
      total_cnt++;
      if (bus8.valid_o !== 1'b0) $display("FAIL reset_valid: got %b want 0", bus8.valid_o);
      else pass_cnt++;
      total_cnt++;
      if (bus8.data_o !== 64'h0) $display("FAIL reset_data: got %h want 0", bus8.data_o);
      else pass_cnt++;
      total_cnt++;
      if (bus8.grant_o !== 3'd0) $display("FAIL reset_grant: got %0d want 0", bus8.grant_o);
      else pass_cnt++;
      bus8.valid_i = 8'h00;
      rst8 = 1'b0;
      rst5 = 1'b0;
   endtask

   task automatic test_single();
      @(negedge clk);
      bus8.valid_i   = 8'h01;
      bus8.data_i[0] = 64'hA5;
      bus8.ready_i   = 1'b1;
      #1;
      total_cnt++;
      if (bus8.ready_o !== 8'h01) $display("FAIL single_ready: got %h want 01", bus8.ready_o);
      else pass_cnt++;
      @(negedge clk);
      total_cnt++;
      if (bus8.valid_o !== 1'b1 || bus8.data_o !== 64'hA5 || bus8.grant_o !== 3'd0)
         $display("FAIL single_out: got v=%b d=%h g=%0d want v=1 d=a5 g=0",
                  bus8.valid_o, bus8.data_o, bus8.grant_o);
      else pass_cnt++;
      $display("beat single grant=%0d data=%h", bus8.grant_o, bus8.data_o);
      bus8.valid_i = 8'h00;
   endtask

   task automatic test_back_to_back();
      @(negedge clk);
      rst8 = 1'b1;
      #1;
      rst8 = 1'b0;
      for (int k = 0; k < 8; k++) bus8.data_i[k] = 64'(k);
      bus8.valid_i = 8'hFF;
      bus8.ready_i = 1'b1;
      for (int i = 0; i < 9; i++) begin
         @(negedge clk);
         total_cnt++;
         if (bus8.valid_o !== 1'b1 || bus8.grant_o !== 3'(i % 8) || bus8.data_o !== 64'(i % 8))
            $display("FAIL b2b_beat%0d: got v=%b g=%0d d=%h want v=1 g=%0d d=%h",
                     i, bus8.valid_o, bus8.grant_o, bus8.data_o, i % 8, i % 8);
         else pass_cnt++;
         $display("beat b2b%0d grant=%0d data=%h", i, bus8.grant_o, bus8.data_o);
      end
      bus8.valid_i = 8'h00;
   endtask

   task automatic test_backpressure();
      // Output holds grant 0 / data 0 from the back-to-back run; pointer is 1.
      bus8.ready_i   = 1'b0;
      bus8.valid_i   = 8'h0C;
      bus8.data_i[2] = 64'h22;
      bus8.data_i[3] = 64'h33;
      for (int i = 0; i < 3; i++) begin
         #1;
         total_cnt++;
         if (bus8.ready_o !== 8'h00 || bus8.valid_o !== 1'b1 || bus8.grant_o !== 3'd0 ||
             bus8.data_o !== 64'h0)
            $display("FAIL hold%0d: got r=%h v=%b g=%0d d=%h want r=00 v=1 g=0 d=0",
                     i, bus8.ready_o, bus8.valid_o, bus8.grant_o, bus8.data_o);
         else pass_cnt++;
         @(negedge clk);
      end
      bus8.ready_i = 1'b1;
      #1;
      total_cnt++;
      if (bus8.ready_o !== 8'h04) $display("FAIL release_ready: got %h want 04", bus8.ready_o);
      else pass_cnt++;
      @(negedge clk);
      total_cnt++;
      if (bus8.valid_o !== 1'b1 || bus8.grant_o !== 3'd2 || bus8.data_o !== 64'h22)
         $display("FAIL release_out: got v=%b g=%0d d=%h want v=1 g=2 d=22",
                  bus8.valid_o, bus8.grant_o, bus8.data_o);
      else pass_cnt++;
      $display("beat release grant=%0d data=%h", bus8.grant_o, bus8.data_o);
      bus8.valid_i = 8'h00;
      @(negedge clk);
      total_cnt++;
      if (bus8.valid_o !== 1'b0 || bus8.grant_o !== 3'd2 || bus8.data_o !== 64'h22)
         $display("FAIL drain: got v=%b g=%0d d=%h want v=0 g=2 d=22",
                  bus8.valid_o, bus8.grant_o, bus8.data_o);
      else pass_cnt++;
   endtask

   task automatic test_wrap5();
      logic [2:0] exp_g;
      bus5.ready_i   = 1'b1;
      bus5.valid_i   = 5'h10;
      bus5.data_i[4] = 64'h44;
      bus5.data_i[0] = 64'h0A;
      #1;
      total_cnt++;
      if (bus5.ready_o !== 5'h10) $display("FAIL w5_ready4: got %h want 10", bus5.ready_o);
      else pass_cnt++;
      @(negedge clk);
      total_cnt++;
      if (bus5.grant_o !== 3'd4 || bus5.data_o !== 64'h44)
         $display("FAIL w5_out4: got g=%0d d=%h want g=4 d=44", bus5.grant_o, bus5.data_o);
      else pass_cnt++;
      bus5.valid_i = 5'h11;
      #1;
      total_cnt++;
      if (bus5.ready_o !== 5'h01) $display("FAIL w5_wrap: got %h want 01", bus5.ready_o);
      else pass_cnt++;
      @(negedge clk);
      total_cnt++;
      if (bus5.grant_o !== 3'd0 || bus5.data_o !== 64'h0A)
         $display("FAIL w5_out0: got g=%0d d=%h want g=0 d=0a", bus5.grant_o, bus5.data_o);
      else pass_cnt++;
      #1;
      total_cnt++;
      if (bus5.ready_o !== 5'h10) $display("FAIL w5_ptr1: got %h want 10", bus5.ready_o);
      else pass_cnt++;
      bus5.valid_i = 5'h1F;
      // Pointer is 1 here: grants run 1,2,3,4,0,1 and never reach 5..7.
      for (int i = 0; i < 6; i++) begin
         exp_g = 3'((i + 1) % 5);
         @(negedge clk);
         total_cnt++;
         if (bus5.grant_o !== exp_g || bus5.valid_o !== 1'b1)
            $display("FAIL w5_seq%0d: got g=%0d v=%b want g=%0d v=1",
                     i, bus5.grant_o, bus5.valid_o, exp_g);
         else pass_cnt++;
         $display("beat w5_%0d grant=%0d", i, bus5.grant_o);
      end
      bus5.valid_i = 5'h00;
   endtask

   task automatic test_async_reset();
      @(negedge clk);
      bus8.ready_i   = 1'b0;
      bus8.valid_i   = 8'h01;
      bus8.data_i[0] = 64'h77;
      @(negedge clk);
      bus8.valid_i = 8'h00;
      total_cnt++;
      if (bus8.valid_o !== 1'b1 || bus8.data_o !== 64'h77)
         $display("FAIL ar_load: got v=%b d=%h want v=1 d=77", bus8.valid_o, bus8.data_o);
      else pass_cnt++;
      #2;
      rst8 = 1'b1;
      #1;
      total_cnt++;
      if (bus8.valid_o !== 1'b0 || bus8.data_o !== 64'h0)
         $display("FAIL ar_drop: got v=%b d=%h want v=0 d=0", bus8.valid_o, bus8.data_o);
      else pass_cnt++;
      #1;
      rst8 = 1'b0;
      @(negedge clk);
      bus8.valid_i   = 8'h81;
      bus8.data_i[7] = 64'h70;
      bus8.data_i[0] = 64'h10;
      bus8.ready_i   = 1'b1;
      #1;
      total_cnt++;
      if (bus8.ready_o !== 8'h01) $display("FAIL ar_ptr: got %h want 01", bus8.ready_o);
      else pass_cnt++;
      @(negedge clk);
      total_cnt++;
      if (bus8.grant_o !== 3'd0 || bus8.data_o !== 64'h10)
         $display("FAIL ar_out: got g=%0d d=%h want g=0 d=10", bus8.grant_o, bus8.data_o);
      else pass_cnt++;
      bus8.valid_i = 8'h00;
   endtask

   task automatic test_priority();
      logic [2:0] exp_g;
      // Pointer is 1 after the grant to channel 0.
      bus8.valid_i   = 8'h0A;
      bus8.data_i[1] = 64'h11;
      bus8.data_i[3] = 64'h33;
      bus8.ready_i   = 1'b1;
      for (int i = 0; i < 4; i++) begin
`ifdef MUX_ARB_FIXED_PRIO_EN
         exp_g = 3'd1;
`else
         exp_g = (i % 2 == 0) ? 3'd1 : 3'd3;
`endif
         @(negedge clk);
         total_cnt++;
         if (bus8.grant_o !== exp_g || bus8.data_o !== ((exp_g == 3'd1) ? 64'h11 : 64'h33))
            $display("FAIL prio%0d: got g=%0d d=%h want g=%0d",
                     i, bus8.grant_o, bus8.data_o, exp_g);
         else pass_cnt++;
         $display("beat prio%0d grant=%0d data=%h", i, bus8.grant_o, bus8.data_o);
      end
      bus8.valid_i = 8'h00;
   endtask

   initial begin
      pass_cnt     = 0;
      total_cnt    = 0;
      rst8         = 1'b1;
      rst5         = 1'b1;
      bus8.data_i  = '0;
      bus8.valid_i = '0;
      bus8.ready_i = 1'b0;
      bus5.data_i  = '0;
      bus5.valid_i = '0;
      bus5.ready_i = 1'b0;

      test_reset();
      test_single();
      test_back_to_back();
      test_backpressure();
      test_wrap5();
      test_async_reset();
      test_priority();

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end
endmodule
